// File: rtl/ifetch_queue_pkg.sv
// Shared fetch-stage definitions: word geometry, reset PC default, queue entry layout.
// No logic; types and helpers only.
// Imported by the fetch queue top and its FIFO.
package ifetch_queue_pkg;

  localparam int          INST_W           = 32;
  localparam int          WORD_BYTES       = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;
  localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

  // One queued fetch: instruction word plus the address it came from.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ALIGN_MASK;
  endfunction

  // Wraps modulo 2^32 with no carry out, so 32'hFFFF_FFFC advances to 32'h0.
  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/ifetch_queue_fetch_fifo.sv
// Synchronous FIFO holding fetched {inst, pc} entries; flush empties it in one edge.
// Latency: a push is visible at the head the cycle after the push edge.
// Backpressure: push is refused when full unless a pop happens the same edge; flush beats push.
module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
  assign head_dat = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Decoupled fetch: owns fetch PC, issues one-outstanding word reads, queues {inst, pc} for decode.
// Latency: memory ack edge -> inst_valid next cycle; zero-wait memory sustains one instruction per cycle.
// Backpressure: new requests only issue while queue plus in-flight fits DEPTH; redirect flushes and drops one stale ack.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]  fetch_pc;
  logic [31:0]  fetch_pc_nxt;
  logic [31:0]  addr_nxt;
  logic         req_nxt;
  logic         discard;
  logic         discard_nxt;
  logic         ack_fire;
  logic         held;
  logic         push;
  logic         pop;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  assign ack_fire   = imem_req && imem_ack;
  // A request raised without ack stays on the bus unchanged, even across a redirect.
  assign held       = imem_req && !imem_ack;
  assign inst_valid = (count != '0);
  // Redirect wins: the word returned on a redirect edge is stale and is never queued.
  assign push       = ack_fire && !discard && !redirect;
  assign pop        = inst_valid && inst_ready && !redirect;

  assign push_entry = '{inst: imem_rdata, pc: imem_addr};

  // Next fetch PC, discard flag and request, with redirect taking priority over push/pop/issue.
  always_comb begin
    count_nxt    = count + CW'(push) - CW'(pop);
    fetch_pc_nxt = fetch_pc;
    discard_nxt  = discard;
    req_nxt      = 1'b0;
    addr_nxt     = imem_addr;

    if (push)     fetch_pc_nxt = next_word(imem_addr);
    if (ack_fire) discard_nxt  = 1'b0;

    if (redirect) begin
      count_nxt    = '0;
      fetch_pc_nxt = word_align(redirect_addr);
      // A second redirect while already discarding leaves the flag set: still one response to drop.
      if (held) discard_nxt = 1'b1;
    end

    // The only in-flight request is a held one, so otherwise issue whenever the queue has room.
    if (held) begin
      req_nxt = 1'b1;
    end else if (count_nxt < CW'(DEPTH)) begin
      req_nxt  = 1'b1;
      addr_nxt = fetch_pc_nxt;
    end
  end

  // Request register, fetch PC and stale-response flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_pc  <= RESET_PC;
      discard   <= 1'b0;
    end else begin
      imem_req  <= req_nxt;
      imem_addr <= addr_nxt;
      fetch_pc  <= fetch_pc_nxt;
      discard   <= discard_nxt;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .flush    (redirect),
    .head_dat (head_entry),
    .count    (count)
  );

  // Head fields read as zero while the queue is empty.
  assign inst          = inst_valid ? head_entry.inst : '0;
  assign inst_pc       = inst_valid ? head_entry.pc : '0;
  assign inst_pc_plus4 = inst_valid ? next_word(head_entry.pc) : '0;

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_pc_plus4 (inst_pc_plus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          ack_wait;    // cycles a request is held before ack
    int          ready_from;  // first cycle with inst_ready=1
    int          cycles;
    int          redir_cycle; // 0 = no redirect
    logic [31:0] redir_addr;
    int          exp_pops;
  } vec_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  vec_t        vecs[6];
  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          pops;
  logic [31:0] bpc;
  logic [31:0] held_addr;
  bit          held;
  bit          drop;
  int          hold_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    redirect = 1'b0;
    redirect_addr = 32'h0;
    inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(inst_valid), 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    bpc = 32'h0;
    held = 1'b0;
    drop = 1'b0;
    hold_cnt = 0;
    held_addr = 32'h0;
  endtask

  // One cycle: sample after the edge, check, drive memory/decode/redirect, update the model.
  task automatic run_cycle(input int ack_wait, input bit rdy, input bit redir, input logic [31:0] raddr);
    bit          req;
    bit          ack;
    bit          valid;
    logic [31:0] cur;
    exp_t        e;
    @(posedge clk);
    #1;
    req   = imem_req;
    valid = inst_valid;
    if (held) begin
      check("req_held", 32'(req), 32'h1);
      check("addr_held", imem_addr, held_addr);
    end else begin
      check("req_issue", 32'(req), 32'(sb.size() < DEPTH));
      if (req) check("addr", imem_addr, bpc);
    end
    check("valid", 32'(valid), 32'(sb.size() != 0));

    ack           = req && (hold_cnt >= ack_wait);
    imem_ack      = ack;
    imem_rdata    = ack ? mem_word(imem_addr) : 32'h0;
    inst_ready    = rdy;
    redirect      = redir;
    redirect_addr = raddr;

    if (valid && rdy && !redir && sb.size() != 0) begin
      e = sb.pop_front();
      check("inst", inst, e.inst);
      check("inst_pc", inst_pc, e.pc);
      check("inst_pc_plus4", inst_pc_plus4, e.pc + 32'd4);
      pops++;
    end

    cur = held ? held_addr : bpc;
    if (redir) begin
      sb.delete();
      bpc = raddr & 32'hFFFF_FFFC;
    end
    if (ack) begin
      if (drop) drop = 1'b0;
      else if (!redir) begin
        sb.push_back('{inst: mem_word(cur), pc: cur});
        bpc = cur + 32'd4;
      end
    end
    if (redir && req && !ack) drop = 1'b1;
    held      = req && !ack;
    held_addr = cur;
    hold_cnt  = held ? hold_cnt + 1 : 0;
  endtask

  initial begin
    vecs[0] = '{"stream",     0, 1, 12, 0, 32'h0,         11};
    vecs[1] = '{"full",       0, 6, 12, 0, 32'h0,         7};
    vecs[2] = '{"wait3",      3, 1, 16, 0, 32'h0,         3};
    vecs[3] = '{"redir_pend", 2, 1, 16, 7, 32'h100,       3};
    vecs[4] = '{"redir_ack",  0, 1, 12, 3, 32'h203,       9};
    vecs[5] = '{"wrap",       0, 1, 10, 2, 32'hFFFF_FFFC, 7};

    for (int v = 0; v < 6; v++) begin
      do_reset();
      pops = 0;
      for (int k = 1; k <= vecs[v].cycles; k++)
        run_cycle(vecs[v].ack_wait, k >= vecs[v].ready_from, k == vecs[v].redir_cycle, vecs[v].redir_addr);
      check({vecs[v].name, "_pops"}, 32'(pops), 32'(vecs[v].exp_pops));
    end

    // Two redirects while the same request is outstanding: one response dropped, fetch resumes at the last target.
    do_reset();
    pops = 0;
    run_cycle(3, 1'b1, 1'b1, 32'h40);
    run_cycle(3, 1'b1, 1'b1, 32'h80);
    for (int k = 3; k <= 9; k++) run_cycle(3, 1'b1, 1'b0, 32'h0);
    check("double_redir_pops", 32'(pops), 32'd1);

    // Reset asserted between edges while a request is pending and the queue is non-empty.
    do_reset();
    pops = 0;
    run_cycle(0, 1'b0, 1'b0, 32'h0);
    run_cycle(9, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #2;
    check("pre_rst_req", 32'(imem_req), 32'h1);
    check("pre_rst_valid", 32'(inst_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(imem_req), 32'h0);
    check("async_rst_valid", 32'(inst_valid), 32'h0);
    check("async_rst_addr", imem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
